seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing controller for the board's 4-digit common-anode seven-segment display. Holds a 16-bit BCD word (four nibbles), walks the anodes one digit at a time at a programmable refresh rate, and drives the shared segment bus through the existing `numToSeg` decoder. Adds a per-digit ghost-blanking gap, decimal points, per-digit blanking, optional leading-zero suppression, and tear-free frame-boundary updates. Sits between the game/score logic and the top-level `seg`/`an` pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 ms at 100 MHz); must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 64: cycles at the start of each slot with all anodes off; must be ≥ 1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `value_in`  in  16  BCD digits; [3:0] = digit 0 (rightmost) … [15:12] = digit 3.
- `dp_in`  in  4  decimal point per digit, active high.
- `blank_in`  in  4  force digit off, active high.
- `lzs_en`  in  1  leading-zero suppression enable.
- `load`  in  1  capture `value_in`/`dp_in`/`blank_in` into pending register this cycle.
- `seg`  out  8  segments, active low; [7] = dp, [6:0] = g..a.
- `an`  out  4  anodes, active low, one-hot-low or all high.
- `frame_start`  out  1  one-cycle pulse when pending is committed to active (start of digit 0 slot).

## Operation
- Registers: pending {value, dp, blank}; active {value, dp, blank}; slot counter `cnt` ($clog2(REFRESH_DIV) bits); digit index `idx` (2 bits); state.
- States: `BLANK` (an=4'b1111, seg=8'hFF) for `cnt` 0..BLANK_CYCLES-1; `DRIVE` for `cnt` BLANK_CYCLES..REFRESH_DIV-1. At `cnt`=REFRESH_DIV-1: `cnt`←0, `idx`←idx+1 (wraps 3→0), state←BLANK.
- Commit: on the cycle `idx` wraps 3→0 (and the first cycle after reset release), active←pending, `frame_start`=1. If `load` is high that same cycle, `value_in`/`dp_in`/`blank_in` go straight to active and pending (bypass).
- `load` on any other cycle only updates pending; active never changes mid-frame.
- DRIVE output for digit i=`idx`: `an`=~(1<<i); `seg[6:0]`=decoder(active nibble i)[6:0]; `seg[7]`=~dp[i].
- Digit off (an still asserted, seg=8'hFF) if blank[i], or if `lzs_en` and i≥1 and nibbles i..3 all zero. Digit 0 never suppressed. dp suppressed along with the digit.
- Nibbles 10–15: decoder yields all-off segments; dp still honoured.
- `lzs_en`, `dp`/`blank` decisions use active copies; `lzs_en` itself sampled live.

## Timing
- Reset values: `an`=4'b1111, `seg`=8'hFF, `frame_start`=0, `cnt`=0, `idx`=0, state=BLANK, pending/active all zero.
- `seg`, `an`, `frame_start` are registered: output reflects state/`cnt`/`idx` one cycle late; no combinational path from inputs to outputs.
- First commit pulse one cycle after `rst_n` deasserts; first DRIVE of digit 0 begins BLANK_CYCLES+1 cycles after release.
- Frame period exactly 4·REFRESH_DIV cycles; `frame_start` period identical.
- Load-to-display latency: ≤ 4·REFRESH_DIV + BLANK_CYCLES + 1 cycles.
- `rst_n` asserted mid-slot: outputs go to reset values immediately (asynchronously); pending load lost.
- `an` never has two bits low; every anode change passes through ≥ BLANK_CYCLES cycles of 4'b1111.

## Structure
- Shared display package: segment-off constant 8'hFF, anode-off constant 4'b1111, digit count 4, state enum {BLANK, DRIVE}.
- One sub-module: instance of the existing `numToSeg` decoder on the muxed active nibble; all sequencing in this block.

## Test plan
Benches run REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset release, `value_in` held 16'h0000, no load -> `an` 1111 for 3 cycles, then 1110 with seg=8'hC0 for 6 cycles; `frame_start` every 32 cycles.
- Load 16'h1234, dp=4'b0100 -> next frame: digit0 seg=8'h99, digit1 seg=8'hB0, digit2 seg=8'h24 (dp on), digit3 seg=8'hF9; frame before unchanged.
- Load 16'h0007, `lzs_en`=1 -> digits 3..1 seg=8'hFF with anode asserted, digit0 seg=8'hF8; with `lzs_en`=0 digits 3..1 show 8'hC0.
- Load asserted exactly on commit cycle with 16'h5555 -> that same frame shows 8'h92 on all digits; load mid-frame with 16'h9999 -> current frame unchanged, next frame 8'h90.
- Nibble 4'hC, blank=4'b0010 -> digit with 4'hC shows 8'hFF, digit1 8'hFF; check `an` never has >1 low bit across 1000 cycles.
- Assert `rst_n` low mid-DRIVE -> same-cycle `an`=1111, `seg`=FF; after release, display 0000 (pending cleared).

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display definitions for the seven-segment scan controller.
package seg_scan_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Display payload held in both the pending and active copies.
    typedef struct packed {
        logic [VALUE_W-1:0]    value;
        logic [NUM_DIGITS-1:0] dp;
        logic [NUM_DIGITS-1:0] blank;
    } disp_t;

endpackage

// File: rtl/seg_scan_ctrl_dec.sv
// numToSeg-compatible BCD to seven-segment decoder, active-low, [6:0] = g..a.
module seg_scan_ctrl_dec (
    input  logic [3:0] num,
    output logic [6:0] seg_c
);

    // Non-decimal codes light nothing.
    always_comb begin
        seg_c = 7'h7F;
        case (num)
            4'd0:    seg_c = 7'h40;
            4'd1:    seg_c = 7'h79;
            4'd2:    seg_c = 7'h24;
            4'd3:    seg_c = 7'h30;
            4'd4:    seg_c = 7'h19;
            4'd5:    seg_c = 7'h12;
            4'd6:    seg_c = 7'h02;
            4'd7:    seg_c = 7'h78;
            4'd8:    seg_c = 7'h00;
            4'd9:    seg_c = 7'h10;
            default: seg_c = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode display scanner with ghost blanking and
// frame-boundary updates of the displayed value.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        lzs_en,
    input  logic        load,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    state_t        state;
    disp_t         pending;
    disp_t         active;

    disp_t         load_word;
    logic          commit;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic          upper_zero;
    logic          digit_off;

    assign load_word = '{value: value_in, dp: dp_in, blank: blank_in};

    // First cycle of digit 0's slot is the frame boundary (also right after reset).
    assign commit = (cnt == '0) && (idx == 2'd0);

    assign nibble = active.value[{idx, 2'b00} +: 4];

    seg_scan_ctrl_dec u_dec (
        .num   (nibble),
        .seg_c (dec_seg)
    );

    // Current digit and every digit above it are zero; digit 0 is never suppressed.
    always_comb begin
        upper_zero = 1'b0;
        case (idx)
            2'd1:    upper_zero = (active.value[15:4]  == 12'h000);
            2'd2:    upper_zero = (active.value[15:8]  == 8'h00);
            2'd3:    upper_zero = (active.value[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
    end

    assign digit_off = active.blank[idx] | (lzs_en & upper_zero);

    // Slot sequencing, frame commit and registered segment/anode drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= 2'd0;
            state       <= BLANK;
            pending     <= '0;
            active      <= '0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= commit;

            if (load) begin
                pending <= load_word;
            end
            if (commit) begin
                active <= load ? load_word : pending;
            end

            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                idx   <= idx + 2'd1;
                state <= BLANK;
            end else begin
                cnt <= cnt + CW'(1);
                if (cnt == BLANK_END) begin
                    state <= DRIVE;
                end
            end

            if (state == DRIVE) begin
                an  <= ~(4'b0001 << idx);
                seg <= digit_off ? SEG_OFF : {~active.dp[idx], dec_seg};
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

    localparam int unsigned RDIV  = 8;
    localparam int unsigned BLANK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  blank_in = 4'b0000;
    logic        lzs_en = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    int         mon_bad = 0;
    logic       mon_en = 1'b0;
    logic [3:0] last_on = 4'hF;
    int         off_run = 0;

    seg_scan_ctrl #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lzs_en      (lzs_en),
        .load        (load),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Anode legality: one-hot-low or all off, and every change of digit
    // preceded by at least BLANK cycles of all-off.
    always @(negedge clk) begin
        if (mon_en) begin
            if (an != 4'hF && an != 4'hE && an != 4'hD && an != 4'hB && an != 4'h7)
                mon_bad = mon_bad + 1;
            if (an == 4'hF) begin
                off_run = off_run + 1;
            end else begin
                if (last_on != 4'hF && an != last_on && off_run < int'(BLANK))
                    mon_bad = mon_bad + 1;
                last_on = an;
                off_run = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step to the next frame_start pulse; position in frame becomes 0.
    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            tick(1);
            n = n + 1;
        end while (frame_start !== 1'b1 && n < 100);
        chk({tag, "_frame_start"}, {31'd0, frame_start}, 32'd1);
    endtask

    // Sample each digit mid-DRIVE; exp = {d3, d2, d1, d0}. Leaves position at 28.
    task automatic check_frame(input logic [31:0] exp, input int start, input string tag);
        int pos = start;
        logic [3:0] an_exp;
        for (int d = 0; d < 4; d++) begin
            tick(8 * d + 4 - pos);
            pos = 8 * d + 4;
            an_exp = ~(4'b0001 << d);
            chk($sformatf("%s_an%0d", tag, d), {28'd0, an}, {28'd0, an_exp});
            chk($sformatf("%s_seg%0d", tag, d), {24'd0, seg}, {24'd0, exp[8*d +: 8]});
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_fs", {31'd0, frame_start}, 32'd0);

        // Release on a falling edge; first commit on the next rising edge.
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick(1);
        chk("rel_fs1", {31'd0, frame_start}, 32'd1);
        chk("rel_an1", {28'd0, an}, 32'hF);
        tick(1);
        chk("rel_fs2", {31'd0, frame_start}, 32'd0);
        chk("rel_an2", {28'd0, an}, 32'hF);
        tick(1);
        chk("rel_an3", {28'd0, an}, 32'hE);
        chk("rel_seg3", {24'd0, seg}, 32'hC0);
        tick(5);
        chk("rel_an8", {28'd0, an}, 32'hE);
        tick(1);
        chk("rel_an9", {28'd0, an}, 32'hF);
        tick(2);
        chk("rel_an11", {28'd0, an}, 32'hD);
        tick(21);
        chk("period_fs32", {31'd0, frame_start}, 32'd0);
        tick(1);
        chk("period_fs33", {31'd0, frame_start}, 32'd1);

        // Mid-frame load of 1234 appears only at the next frame.
        value_in = 16'h1234; dp_in = 4'b0100;
        load = 1'b1; tick(1); load = 1'b0;
        check_frame(32'hC0C0C0C0, 1, "old");
        wait_frame("f1234");
        check_frame(32'hF924B099, 0, "v1234");

        // Leading-zero suppression on 0007, then disabled live.
        value_in = 16'h0007; dp_in = 4'b0000; lzs_en = 1'b1;
        load = 1'b1; tick(1); load = 1'b0;
        wait_frame("flzs");
        check_frame(32'hFFFFFFF8, 0, "lzs1");
        lzs_en = 1'b0;
        wait_frame("fnolzs");
        check_frame(32'hC0C0C0F8, 0, "lzs0");

        // Load on the commit cycle bypasses straight to this frame.
        tick(3);
        value_in = 16'h5555;
        load = 1'b1; tick(1); load = 1'b0;
        chk("byp_fs", {31'd0, frame_start}, 32'd1);
        check_frame(32'h92929292, 0, "byp");

        // Load mid-frame: current frame unchanged, next frame shows 9999.
        wait_frame("f5555b");
        value_in = 16'h9999;
        load = 1'b1; tick(1); load = 1'b0;
        check_frame(32'h92929292, 1, "hold");
        wait_frame("f9999");
        check_frame(32'h90909090, 0, "v9999");

        // Non-decimal nibble, blanked digit with dp, dp on digit 0.
        value_in = 16'h3C05; dp_in = 4'b0011; blank_in = 4'b0010;
        load = 1'b1; tick(1); load = 1'b0;
        wait_frame("fblank");
        check_frame(32'hB0FFFF12, 0, "blk");
        blank_in = 4'b0000;

        tick(800);
        mon_en = 1'b0;
        chk("an_legal", mon_bad, 32'd0);

        // Asynchronous reset mid-DRIVE drops outputs and the pending load.
        wait_frame("frst");
        value_in = 16'h8888;
        load = 1'b1; tick(1); load = 1'b0;
        tick(3);
        chk("pre_rst_an", {28'd0, an}, 32'hE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_an", {28'd0, an}, 32'hF);
        chk("async_seg", {24'd0, seg}, 32'hFF);
        chk("async_fs", {31'd0, frame_start}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("rel2_fs", {31'd0, frame_start}, 32'd1);
        check_frame(32'hC0C0C0C0, 0, "cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
